inst_loader: RTL and testbench
==============================

Name: inst_loader

Overview:
- Upstream feeder of the IF-stage instruction memory's write port.
- Receives program bytes from the debug unit's UART receive path and writes them into instruction memory at consecutive byte addresses from 0, one byte per write.
- Stops when a complete 32-bit HALT word has been stored, and reports the instruction count.
- Flags an error if memory fills before HALT arrives.

Parameters:
- ADDR_SIZE, 8, instruction memory byte-address width.
- MEM_SIZE, 8, byte width; must equal the rx data width.
- MEM_LARGE, 256, memory depth in bytes; must equal 2**ADDR_SIZE and be a multiple of 4.
- INST_SIZE, 32, instruction width; exactly 4 bytes.
- HALT_INST, 32'hFFFFFFFF, end-of-program instruction encoding.

Ports:
- i_clock  in  1  system clock.
- i_reset  in  1  asynchronous, active-low reset.
- i_start  in  1  single-cycle request from the debug unit to begin a load.
- i_rx_data  in  MEM_SIZE  received byte.
- i_rx_valid  in  1  single-cycle strobe; i_rx_data is valid this cycle.
- o_write_enable  out  1  instruction memory byte write strobe.
- o_write_addr  out  ADDR_SIZE  instruction memory write address.
- o_write_data  out  MEM_SIZE  instruction memory write byte.
- o_enable  out  1  instruction memory enable while loading.
- o_busy  out  1  load in progress.
- o_done  out  1  single-cycle pulse: HALT word stored.
- o_error  out  1  sticky overflow flag, cleared by the next accepted i_start.
- o_inst_count  out  ADDR_SIZE-1  completed instructions stored, including HALT.

Behaviour:
- Reset (asynchronous, i_reset=0):
  - State IDLE.
  - All outputs 0; all internal counters and the word shift register 0.
  - Memory contents untouched.
  - Reset mid-load aborts immediately; no further writes; o_done is not pulsed.
- States: IDLE, RECV, DONE, ERROR.
- IDLE/ERROR, on i_start=1:
  - Clear address, byte counter, word register, o_inst_count and o_error.
  - Next state RECV.
  - i_rx_valid is ignored in IDLE, DONE and ERROR.
- RECV:
  - o_busy=1, o_enable=1.
  - i_start is ignored.
  - On i_rx_valid, capture the byte.
  - In the next cycle: o_write_enable=1 for exactly one cycle, o_write_addr = current address, o_write_data = captured byte.
  - Address increments by 1 per accepted byte. Write latency is 1 cycle.
  - Back-to-back i_rx_valid (every cycle) must be accepted with no byte loss.
- Byte order is big-endian: byte k of an instruction goes to address 4n+k, and byte 0 holds bits [31:24]. This matches the instruction memory's read assembly.
- A 2-bit byte counter and a shift register assemble the word. On capture of byte 3:
  - o_inst_count increments.
  - If {word[23:0], byte} == HALT_INST: next state DONE.
  - Else if the captured address == MEM_LARGE-1: next state ERROR (overflow).
  - Else stay in RECV.
- The HALT word is itself written to memory. Its 4th-byte write occurs in the same cycle the FSM is in DONE/ERROR.
- o_enable stays 1 through that trailing write cycle.
- HALT occupying the last slot (bytes MEM_LARGE-4 to MEM_LARGE-1) gives DONE, not ERROR.
- DONE:
  - o_done=1 for one cycle; o_busy=0.
  - Next state IDLE.
  - o_inst_count holds until the next i_start.
- ERROR:
  - o_error=1, o_busy=0; no writes.
  - Held until i_start or reset.
- Address never wraps to 0 within a load.
- A HALT pattern split across instruction boundaries is not detected; only aligned words are compared.
- Simultaneous i_start and i_rx_valid in IDLE: start is taken, the byte is dropped.

Test Plan:
- Start, then bytes 20 01 00 05, 00 00 00 00, FF FF FF FF at 16-cycle spacing -> 12 writes at addr 0..11 with matching data; o_done pulses once on the cycle after the byte-11 capture; o_inst_count=3; o_busy falls with o_done.
- Same 12 bytes with i_rx_valid held high 12 consecutive cycles -> 12 consecutive write cycles, addr 0..11, no gaps or loss.
- 252 bytes of 00 then FF FF FF FF -> last write at addr 255; o_done=1, o_error=0; o_inst_count=64.
- 256 bytes of 00 -> 256 writes; o_error=1 after byte 255; further bytes produce no writes; i_start clears o_error and restarts at addr 0.
- Reset pulsed low after 6 bytes -> all outputs 0 asynchronously; bytes after reset are ignored until i_start; the new load starts at addr 0.
- i_start pulsed while loading after 2 bytes -> ignored; the load continues at addr 2; bytes FF FF 00 FF at addr 4..7 are not treated as HALT.

Source files
------------

// File: rtl/inst_loader.sv
// inst_loader: streams received program bytes into instruction memory,
// big-endian, from address 0 until an aligned HALT word has been stored.
module inst_loader #(
  parameter int unsigned          ADDR_SIZE = 8,
  parameter int unsigned          MEM_SIZE  = 8,
  parameter int unsigned          MEM_LARGE = 256,
  parameter int unsigned          INST_SIZE = 32,
  parameter logic [INST_SIZE-1:0] HALT_INST = 32'hFFFFFFFF
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_start,
  input  logic [MEM_SIZE-1:0]  i_rx_data,
  input  logic                 i_rx_valid,
  output logic                 o_write_enable,
  output logic [ADDR_SIZE-1:0] o_write_addr,
  output logic [MEM_SIZE-1:0]  o_write_data,
  output logic                 o_enable,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_error,
  output logic [ADDR_SIZE-2:0] o_inst_count
);

  localparam int unsigned WORD_W = INST_SIZE - MEM_SIZE;
  localparam int unsigned CNT_W  = ADDR_SIZE - 1;
  localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(MEM_LARGE - 1);

  typedef enum logic [1:0] {IDLE, RECV, DONE, ERROR} state_t;

  state_t               state_q, state_d;
  logic [ADDR_SIZE-1:0] addr_q, addr_d;
  logic [1:0]           byte_cnt_q, byte_cnt_d;
  logic [WORD_W-1:0]    word_q, word_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 wr_en_q, wr_en_d;
  logic [ADDR_SIZE-1:0] wr_addr_q, wr_addr_d;
  logic [MEM_SIZE-1:0]  wr_data_q, wr_data_d;
  logic                 enable_q, enable_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 error_q, error_d;

  // State register
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Datapath and registered outputs
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      addr_q     <= '0;
      byte_cnt_q <= '0;
      word_q     <= '0;
      count_q    <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      enable_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      addr_q     <= addr_d;
      byte_cnt_q <= byte_cnt_d;
      word_q     <= word_d;
      count_q    <= count_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      enable_q   <= enable_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  // Next state and next output values; the last byte's write trails into DONE/ERROR
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    byte_cnt_d = byte_cnt_q;
    word_d     = word_q;
    count_d    = count_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    enable_d   = 1'b0;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    error_d    = error_q;

    unique case (state_q)
      IDLE, ERROR: begin
        if (i_start) begin
          state_d    = RECV;
          addr_d     = '0;
          byte_cnt_d = '0;
          word_d     = '0;
          count_d    = '0;
          error_d    = 1'b0;
          enable_d   = 1'b1;
          busy_d     = 1'b1;
        end
      end
      RECV: begin
        enable_d = 1'b1;
        busy_d   = 1'b1;
        if (i_rx_valid) begin
          wr_en_d    = 1'b1;
          wr_addr_d  = addr_q;
          wr_data_d  = i_rx_data;
          addr_d     = addr_q + ADDR_SIZE'(1);
          byte_cnt_d = byte_cnt_q + 2'd1;
          word_d     = {word_q[WORD_W-MEM_SIZE-1:0], i_rx_data};
          if (byte_cnt_q == 2'd3) begin
            count_d = count_q + CNT_W'(1);
            if ({word_q, i_rx_data} == HALT_INST) begin
              state_d = DONE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end else if (addr_q == LAST_ADDR) begin
              state_d = ERROR;
              busy_d  = 1'b0;
              error_d = 1'b1;
            end
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_write_enable = wr_en_q;
  assign o_write_addr   = wr_addr_q;
  assign o_write_data   = wr_data_q;
  assign o_enable       = enable_q;
  assign o_busy         = busy_q;
  assign o_done         = done_q;
  assign o_error        = error_q;
  assign o_inst_count   = count_q;

endmodule

// File: tb/tb_inst_loader.sv
// Directed bench for inst_loader with a write scoreboard fed by a byte-level model.
module tb_inst_loader;

  logic       clk;
  logic       rst_n;
  logic       i_start;
  logic [7:0] i_rx_data;
  logic       i_rx_valid;
  logic       o_write_enable;
  logic [7:0] o_write_addr;
  logic [7:0] o_write_data;
  logic       o_enable;
  logic       o_busy;
  logic       o_done;
  logic       o_error;
  logic [6:0] o_inst_count;

  int checks = 0;
  int errors = 0;
  int n_writes = 0;
  int n_done = 0;

  logic [15:0] exp_q[$];

  // bench model of the loader, used only to predict writes
  logic        m_loading = 1'b0;
  logic [7:0]  m_addr = '0;
  logic [1:0]  m_cnt = '0;
  logic [31:0] m_word = '0;

  inst_loader dut (
    .i_clock        (clk),
    .i_reset        (rst_n),
    .i_start        (i_start),
    .i_rx_data      (i_rx_data),
    .i_rx_valid     (i_rx_valid),
    .o_write_enable (o_write_enable),
    .o_write_addr   (o_write_addr),
    .o_write_data   (o_write_data),
    .o_enable       (o_enable),
    .o_busy         (o_busy),
    .o_done         (o_done),
    .o_error        (o_error),
    .o_inst_count   (o_inst_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic model_start();
    m_loading = 1'b1;
    m_addr    = '0;
    m_cnt     = '0;
    m_word    = '0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (m_loading) begin
      exp_q.push_back({m_addr, b});
      m_word = {m_word[23:0], b};
      if (m_cnt == 2'd3) begin
        if (m_word == 32'hFFFFFFFF) m_loading = 1'b0;
        else if (m_addr == 8'hFF)   m_loading = 1'b0;
      end
      m_cnt  = m_cnt + 2'd1;
      m_addr = m_addr + 8'd1;
    end
  endtask

  task automatic start_load();
    i_start = 1'b1;
    cyc();
    i_start = 1'b0;
    model_start();
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    i_rx_valid = 1'b1;
    i_rx_data  = b;
    model_byte(b);
    cyc();
    i_rx_valid = 1'b0;
    repeat (gap) cyc();
  endtask

  // Scoreboard: every write strobe must match the oldest predicted write
  always @(negedge clk) begin
    if (o_write_enable) begin
      n_writes++;
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_write observed addr=%0h data=%0h expected no write", o_write_addr, o_write_data);
      end
      if (exp_q.size() != 0) begin
        logic [15:0] e;
        e = exp_q.pop_front();
        check("wr_addr", 32'(o_write_addr), 32'(e[15:8]));
        check("wr_data", 32'(o_write_data), 32'(e[7:0]));
      end
    end
    if (o_done) n_done++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  logic [7:0] prog[12];
  int done_base;
  int wr_snap;

  initial begin
    prog = '{8'h20, 8'h01, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00,
             8'hFF, 8'hFF, 8'hFF, 8'hFF};
    rst_n = 1'b0; i_start = 1'b0; i_rx_valid = 1'b0; i_rx_data = '0;
    repeat (3) cyc();
    check("rst_busy", 32'(o_busy), 0);
    check("rst_we", 32'(o_write_enable), 0);
    check("rst_count", 32'(o_inst_count), 0);
    rst_n = 1'b1;
    cyc();

    // bytes in IDLE are ignored
    send_byte(8'h77, 2);
    check("idle_no_write", 32'(n_writes), 0);

    // program at 16-cycle spacing
    done_base = n_done;
    start_load();
    check("start_busy", 32'(o_busy), 1);
    check("start_enable", 32'(o_enable), 1);
    for (int i = 0; i < 11; i++) send_byte(prog[i], 15);
    send_byte(prog[11], 0);
    @(negedge clk);
    check("t1_done", 32'(o_done), 1);
    check("t1_busy", 32'(o_busy), 0);
    check("t1_enable", 32'(o_enable), 1);
    check("t1_count", 32'(o_inst_count), 3);
    check("t1_error", 32'(o_error), 0);
    @(posedge clk); #1;
    repeat (3) cyc();
    check("t1_done_once", 32'(n_done - done_base), 1);
    check("t1_enable_off", 32'(o_enable), 0);
    check("t1_count_hold", 32'(o_inst_count), 3);
    check("t1_sb_empty", 32'(exp_q.size()), 0);

    // start with a simultaneous byte, then back-to-back bytes
    i_start = 1'b1; i_rx_valid = 1'b1; i_rx_data = 8'h55;
    cyc();
    i_start = 1'b0; i_rx_valid = 1'b0;
    model_start();
    for (int i = 0; i < 12; i++) begin
      i_rx_valid = 1'b1;
      i_rx_data  = prog[i];
      model_byte(prog[i]);
      @(negedge clk);
      check("b2b_we", 32'(o_write_enable), (i > 0) ? 1 : 0);
      @(posedge clk); #1;
    end
    i_rx_valid = 1'b0;
    @(negedge clk);
    check("b2b_last_we", 32'(o_write_enable), 1);
    check("b2b_done", 32'(o_done), 1);
    @(posedge clk); #1;
    repeat (2) cyc();
    check("b2b_sb_empty", 32'(exp_q.size()), 0);

    // HALT in the last slot
    start_load();
    for (int i = 0; i < 252; i++) send_byte(8'h00, 1);
    for (int i = 0; i < 3; i++) send_byte(8'hFF, 1);
    send_byte(8'hFF, 0);
    @(negedge clk);
    check("full_done", 32'(o_done), 1);
    check("full_error", 32'(o_error), 0);
    check("full_addr", 32'(o_write_addr), 255);
    check("full_count", 32'(o_inst_count), 64);
    @(posedge clk); #1;
    repeat (2) cyc();
    check("full_sb_empty", 32'(exp_q.size()), 0);

    // overflow without HALT
    start_load();
    for (int i = 0; i < 255; i++) send_byte(8'h00, 1);
    send_byte(8'h00, 0);
    @(negedge clk);
    check("ovf_error", 32'(o_error), 1);
    check("ovf_busy", 32'(o_busy), 0);
    check("ovf_done", 32'(o_done), 0);
    check("ovf_addr", 32'(o_write_addr), 255);
    check("ovf_count", 32'(o_inst_count), 64);
    @(posedge clk); #1;
    cyc();
    wr_snap = n_writes;
    for (int i = 0; i < 3; i++) send_byte(8'h33, 1);
    check("ovf_no_write", 32'(n_writes - wr_snap), 0);
    check("ovf_sticky", 32'(o_error), 1);
    start_load();
    check("ovf_clear", 32'(o_error), 0);
    check("ovf_restart_busy", 32'(o_busy), 1);
    send_byte(8'h11, 1); send_byte(8'h22, 1); send_byte(8'h33, 1); send_byte(8'h44, 1);
    for (int i = 0; i < 3; i++) send_byte(8'hFF, 1);
    send_byte(8'hFF, 0);
    @(negedge clk);
    check("ovf_restart_done", 32'(o_done), 1);
    check("ovf_restart_count", 32'(o_inst_count), 2);
    @(posedge clk); #1;
    cyc();

    // asynchronous reset with a write in flight
    start_load();
    for (int i = 0; i < 5; i++) send_byte(8'(i + 1), 1);
    send_byte(8'h06, 0);
    #1;
    rst_n = 1'b0;
    #1;
    void'(exp_q.pop_back());
    m_loading = 1'b0;
    check("ar_we", 32'(o_write_enable), 0);
    check("ar_addr", 32'(o_write_addr), 0);
    check("ar_data", 32'(o_write_data), 0);
    check("ar_busy", 32'(o_busy), 0);
    check("ar_enable", 32'(o_enable), 0);
    check("ar_count", 32'(o_inst_count), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc();
    wr_snap = n_writes;
    for (int i = 0; i < 3; i++) send_byte(8'h99, 1);
    check("ar_ignored", 32'(n_writes - wr_snap), 0);
    check("ar_idle_busy", 32'(o_busy), 0);
    start_load();
    for (int i = 0; i < 7; i++) send_byte(prog[i < 4 ? i : i + 4], 1);
    send_byte(8'hFF, 0);
    @(negedge clk);
    check("ar_reload_done", 32'(o_done), 1);
    check("ar_reload_count", 32'(o_inst_count), 2);
    @(posedge clk); #1;
    cyc();

    // start during a load is ignored; split-looking HALT bytes are not HALT
    done_base = n_done;
    start_load();
    send_byte(8'h01, 2); send_byte(8'h02, 2);
    i_start = 1'b1;
    cyc();
    i_start = 1'b0;
    send_byte(8'h03, 2); send_byte(8'h04, 2);
    send_byte(8'hFF, 2); send_byte(8'hFF, 2); send_byte(8'h00, 2); send_byte(8'hFF, 2);
    check("mid_busy", 32'(o_busy), 1);
    check("mid_no_done", 32'(n_done - done_base), 0);
    check("mid_count", 32'(o_inst_count), 2);
    for (int i = 0; i < 3; i++) send_byte(8'hFF, 2);
    send_byte(8'hFF, 0);
    @(negedge clk);
    check("mid_done", 32'(o_done), 1);
    check("mid_count_final", 32'(o_inst_count), 3);
    @(posedge clk); #1;
    repeat (2) cyc();
    check("final_sb_empty", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
